// File: rtl/cpu4_mem_pkg.sv
// Shared types and default widths for the cpu4 instruction/data memory arbiter.
package cpu4_mem_pkg;

  localparam int CPU4_AW = 8;
  localparam int CPU4_DW = 32;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_I    = 2'd1,
    PEND_D    = 2'd2
  } pend_src_t;

endpackage

// File: rtl/cpu4_mem_arbiter_if.sv
// Bus bundle between the cpu4 fetch/data ports, the arbiter and the single-port RAM.
interface cpu4_mem_arbiter_if #(
  parameter int AW = cpu4_mem_pkg::CPU4_AW,
  parameter int DW = cpu4_mem_pkg::CPU4_DW
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cpu4_arb_pick.sv
// Combinational grant selection: data wins unless the starvation guard forces a fetch.
module cpu4_arb_pick (
  input  logic i_fetch_req,
  input  logic i_data_req,
  input  logic i_starve_force,
  output logic o_fetch_gnt,
  output logic o_data_gnt
);

  assign o_data_gnt  = i_data_req & ~i_starve_force;
  assign o_fetch_gnt = i_fetch_req & (~i_data_req | i_starve_force);

endmodule

// File: rtl/cpu4_mem_arbiter.sv
// Fetch/data arbiter in front of one single-port word RAM with 1-cycle read return.
// Optional fetch starvation guard enabled by defining CPU4_ARB_STARVE_GUARD_EN.
module cpu4_mem_arbiter
  import cpu4_mem_pkg::*;
#(
  parameter int AW           = CPU4_AW,
  parameter int DW           = CPU4_DW,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  cpu4_mem_arbiter_if.slave   bus
);

  logic          w_i_req;
  logic          w_d_req;
  logic          w_i_gnt;
  logic          w_d_gnt;
  logic          w_starve_force;
  logic          w_i_ret;
  logic          w_d_ret;
  pend_src_t     r_pend_src;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;

  // Requests are masked while reset is low so nothing is granted during reset.
  assign w_i_req = bus.i_req & reset;
  assign w_d_req = bus.d_req & reset;

  cpu4_arb_pick u_pick (
    .i_fetch_req    (w_i_req),
    .i_data_req     (w_d_req),
    .i_starve_force (w_starve_force),
    .o_fetch_gnt    (w_i_gnt),
    .o_data_gnt     (w_d_gnt)
  );

`ifdef CPU4_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] r_d_streak;

  assign w_starve_force = w_i_req & (r_d_streak == STREAK_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_d_streak <= '0;
    end else if (w_i_gnt || !w_i_req) begin
      r_d_streak <= '0;
    end else if (w_d_gnt) begin
      r_d_streak <= r_d_streak + SW'(1);
    end
  end
`else
  assign w_starve_force = 1'b0;
`endif

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_i_gnt | w_d_gnt;
  assign bus.mem_we    = w_d_gnt & bus.d_we;
  assign bus.mem_addr  = w_d_gnt ? bus.d_addr : (w_i_gnt ? bus.i_addr : '0);
  assign bus.mem_wdata = (w_d_gnt & bus.d_we) ? bus.d_wdata : '0;

  // Owner of the RAM read data arriving next cycle; stores never return data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend_src <= PEND_NONE;
    end else if (w_d_gnt && !bus.d_we) begin
      r_pend_src <= PEND_D;
    end else if (w_i_gnt) begin
      r_pend_src <= PEND_I;
    end else begin
      r_pend_src <= PEND_NONE;
    end
  end

  // A return landing while reset is low belongs to a dropped read.
  assign w_i_ret = reset & (r_pend_src == PEND_I);
  assign w_d_ret = reset & (r_pend_src == PEND_D);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_i_ret) r_i_rdata <= bus.mem_rdata;
      if (w_d_ret) r_d_rdata <= bus.mem_rdata;
    end
  end

  assign bus.i_rvalid = w_i_ret;
  assign bus.d_rvalid = w_d_ret;
  assign bus.i_rdata  = w_i_ret ? bus.mem_rdata : r_i_rdata;
  assign bus.d_rdata  = w_d_ret ? bus.mem_rdata : r_d_rdata;

endmodule

// File: tb/tb_cpu4_mem_arbiter.sv
// Scoreboard bench for cpu4_mem_arbiter with a write-first single-port RAM model.
module tb_cpu4_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  exp_t        exp_i[$];
  exp_t        exp_d[$];
  exp_t        ei;
  exp_t        ed;
  logic [31:0] last_i;
  logic [31:0] last_d;
  logic [31:0] ram [0:255];

  cpu4_mem_arbiter_if #(.AW(8), .DW(32)) bus ();

  cpu4_mem_arbiter #(.AW(8), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-first synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata     <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.i_rvalid === 1'b1) begin
      if (exp_i.size() == 0) begin
        chk("i_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        ei = exp_i.pop_front();
        chk("i_rdata", bus.i_rdata, ei.data);
        chk("i_rvalid_cycle", 32'(cyc), 32'(ei.cyc));
      end
      last_i = bus.i_rdata;
    end else begin
      chk("i_rdata_hold", bus.i_rdata, last_i);
    end
    if (bus.d_rvalid === 1'b1) begin
      if (exp_d.size() == 0) begin
        chk("d_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        ed = exp_d.pop_front();
        chk("d_rdata", bus.d_rdata, ed.data);
        chk("d_rvalid_cycle", 32'(cyc), 32'(ed.cyc));
      end
      last_d = bus.d_rdata;
    end else begin
      chk("d_rdata_hold", bus.d_rdata, last_d);
    end
    if (reset === 1'b0) begin
      last_i = 32'd0;
      last_d = 32'd0;
    end
  end

  task automatic drive(input logic ir, input logic [7:0] ia, input logic dr,
                       input logic dw, input logic [7:0] da, input logic [31:0] dd);
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
  endtask

  task automatic push_i(input logic [31:0] d);
    exp_i.push_back('{data: d, cyc: cyc + 1});
  endtask

  task automatic push_d(input logic [31:0] d);
    exp_d.push_back('{data: d, cyc: cyc + 1});
  endtask

  task automatic cyc_check(input string nm, input logic eig, input logic edg, input logic [7:0] ea,
                           input logic ewe, input logic [31:0] ewd);
    @(negedge clk);
    chk({nm, "_i_gnt"}, 32'(bus.i_gnt), 32'(eig));
    chk({nm, "_d_gnt"}, 32'(bus.d_gnt), 32'(edg));
    chk({nm, "_mem_en"}, 32'(bus.mem_en), 32'(eig | edg));
    chk({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'(ea));
    chk({nm, "_mem_we"}, 32'(bus.mem_we), 32'(ewe));
    chk({nm, "_mem_wdata"}, bus.mem_wdata, ewd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fetch_exp [0:2];
    logic        ig;
    checks = 0;
    errors = 0;
    last_i = 32'd0;
    last_d = 32'd0;
    for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 + 32'(i);
    ram[0] = 32'h11;
    ram[1] = 32'h22;
    ram[2] = 32'h33;
    ram[5] = 32'h55;
    ram[7] = 32'h77;
    fetch_exp[0] = 32'h11;
    fetch_exp[1] = 32'h22;
    fetch_exp[2] = 32'h33;

    // Reset with both requests high: nothing may be granted.
    reset = 1'b0;
    drive(1'b1, 8'd1, 1'b1, 1'b0, 8'd2, 32'd0);
    @(posedge clk);
    #1;
    cyc_check("rst", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    reset = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    cyc_check("idle0", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);

    // Back-to-back fetches.
    for (int a = 0; a < 3; a++) begin
      drive(1'b1, 8'(a), 1'b0, 1'b0, 8'd0, 32'd0);
      push_i(fetch_exp[a]);
      cyc_check("fetch", 1'b1, 1'b0, 8'(a), 1'b0, 32'd0);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    cyc_check("idle1", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);

    // Collision: load wins, fetch follows with the load return in the same cycle.
    drive(1'b1, 8'd5, 1'b1, 1'b0, 8'd7, 32'd0);
    push_d(32'h77);
    cyc_check("coll_d", 1'b0, 1'b1, 8'd7, 1'b0, 32'd0);
    drive(1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 32'd0);
    push_i(32'h55);
    cyc_check("coll_i", 1'b1, 1'b0, 8'd5, 1'b0, 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    cyc_check("idle2", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);

    // Store then load of the same word.
    drive(1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 32'hDEAD_BEEF);
    cyc_check("store", 1'b0, 1'b1, 8'd3, 1'b1, 32'hDEAD_BEEF);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 32'd0);
    push_d(32'hDEAD_BEEF);
    cyc_check("raw_load", 1'b0, 1'b1, 8'd3, 1'b0, 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    cyc_check("idle3", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);

    // Reset while a fetch is in flight: its data must never be returned.
    drive(1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 32'd0);
    cyc_check("pre_rst", 1'b1, 1'b0, 8'd1, 1'b0, 32'd0);
    reset = 1'b0;
    drive(1'b1, 8'd1, 1'b1, 1'b0, 8'd2, 32'd0);
    cyc_check("mid_rst", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    reset = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    cyc_check("post_rst0", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    cyc_check("post_rst1", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);

    // Cancelled fetch while loads occupy the RAM.
    drive(1'b1, 8'd2, 1'b1, 1'b0, 8'd7, 32'd0);
    push_d(32'h77);
    cyc_check("cancel0", 1'b0, 1'b1, 8'd7, 1'b0, 32'd0);
    drive(1'b0, 8'd2, 1'b1, 1'b0, 8'd8, 32'd0);
    push_d(32'hA000_0008);
    cyc_check("cancel1", 1'b0, 1'b1, 8'd8, 1'b0, 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    cyc_check("cancel2", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    cyc_check("idle4", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);

    // Both ports held busy for ten cycles.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'd6, 1'b1, 1'b0, 8'd4, 32'd0);
`ifdef CPU4_ARB_STARVE_GUARD_EN
      ig = ((k % 5) == 4);
`else
      ig = 1'b0;
`endif
      if (ig) begin
        push_i(32'hA000_0006);
        cyc_check("starve_i", 1'b1, 1'b0, 8'd6, 1'b0, 32'd0);
      end else begin
        push_d(32'hA000_0004);
        cyc_check("starve_d", 1'b0, 1'b1, 8'd4, 1'b0, 32'd0);
      end
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
    cyc_check("idle5", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    cyc_check("idle6", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);

    chk("i_returns_pending", 32'(exp_i.size()), 32'd0);
    chk("d_returns_pending", 32'(exp_d.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu4_mem_arbiter.md
Name: cpu4_mem_arbiter

Overview:
- Shares one single-port synchronous word RAM between the cpu4 instruction-fetch port and the data load/store port.
- Lets the core run from a single physical memory instead of separate icache/dcache arrays.
- Grants at most one access per cycle, tracks the outstanding read, and routes returned data back to the requester that issued it.
- Sits between cpu4_core and the RAM at the top level.

Parameters:
- AW, 8, word-address width; byte address bits [AW+1:2].
- DW, 32, data width.
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low: block in reset while reset==0, sampled on the clk edge.
- i_req  in  1  fetch request.
- i_addr  in  AW  fetch word address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  DW  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  d_rdata valid (loads only).
- d_rdata  out  DW  load data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM word address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- Grant is combinational in the request cycle.
- i_gnt and d_gnt are never both 1. mem_en = i_gnt | d_gnt.
- mem_addr/mem_we/mem_wdata come from the granted port. When idle, mem_addr/mem_wdata hold 0 and mem_we=0.
- Handshake: a requester holds req, addr, we and wdata stable until it sees gnt. It may drop or change them the cycle after gnt. Deasserting req before gnt is legal and cancels the request.
- Priority: d_req beats i_req (avoids pipeline deadlock on load/store stalls).
- Read latency 1: a read granted in cycle N returns *_rvalid=1 with *_rdata=mem_rdata in cycle N+1.
- Register pend_src in {NONE, I, D} records which port owns the returning data.
- A new access may be granted in the same cycle a previous read returns, giving full throughput of one access per cycle.
- Stores: d_gnt in cycle N, RAM written at the end of N. No d_rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data; the RAM is write-first, and the arbiter adds no forwarding.
- *_rdata holds its last value when *_rvalid=0. *_rvalid is high for exactly one cycle per granted read.
- Reset (reset==0 at the edge):
  - pend_src <= NONE; rvalid outputs <= 0; rdata registers <= 0; streak counter <= 0.
  - A read in flight when reset is applied is dropped: no rvalid after reset.
  - While reset==0, i_gnt=d_gnt=mem_en=0.
- Simultaneous i_req & d_req with d_we=1: store granted, fetch waits. The fetch is granted the next cycle if d_req is low.

Optional Feature:
- Macro CPU4_ARB_STARVE_GUARD_EN.
- When defined:
  - A counter d_streak (width clog2(MAX_D_STREAK+1)) increments on each d_gnt issued while i_req=1.
  - When d_streak==MAX_D_STREAK and i_req=1, the next grant goes to fetch even if d_req=1.
  - The counter clears on any i_gnt or any cycle with i_req=0.
- When undefined: strict data priority, no counter logic.

Decomposition:
- Package cpu4_mem_pkg:
  - enum pend_src_t {PEND_NONE, PEND_I, PEND_D}.
  - localparams CPU4_AW=8, CPU4_DW=32.
- One natural sub-module, cpu4_arb_pick: purely combinational selection of i_gnt/d_gnt from i_req, d_req and starve_force.
- Tracking, return routing and the streak counter stay in the parent.

Test Plan:
- Fetch-only stream: i_req=1 at addresses 0,1,2 over 3 cycles, RAM preloaded 0x11,0x22,0x33. Expect i_gnt each cycle and i_rvalid on cycles 2-4 with 0x11,0x22,0x33.
- Collision: i_req=1 addr 5 and d_req=1 load addr 7 in the same cycle. Expect d_gnt first, d_rvalid with mem[7] next cycle, i_gnt that same next cycle, then i_rvalid with mem[5].
- Store then load: d_we=1 addr 3 data 0xDEADBEEF, then d_we=0 addr 3 the following cycle. Expect d_rvalid with d_rdata=0xDEADBEEF two cycles after the store grant.
- Reset mid-read: grant a fetch at addr 1, then drive reset=0 the next edge. Expect i_rvalid=0, mem_en=0 during reset, and no stale rvalid after reset returns to 1.
- Starvation (with CPU4_ARB_STARVE_GUARD_EN, MAX_D_STREAK=4): hold d_req and i_req high. Expect 4 d_gnt, then 1 i_gnt, then repeat. Without the macro, i_gnt never asserts.
- Cancel: raise i_req while d_req holds the RAM, then drop i_req before grant. Expect no i_gnt and no i_rvalid.
